// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// The segment table is ordered {A,B,C,D,E,F,G}, active-high.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] code;
    logic        dp_en;
    logic [1:0]  dp_pos;
    logic        blank_lz;
  } disp_val_t;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF    = 7'b000_0000;

  // Index 15 is listed first so HEX_SEG[code] selects the pattern for code.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to seven-segment pattern decoder.
module seg_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[code_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with dead time, frame-aligned
// value updates through a load/ready shadow register, and leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int TICK_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        load_i,
  output logic        ready_o,
  input  logic [15:0] digit_code_i,
  input  logic        dp_en_i,
  input  logic [1:0]  dp_pos_i,
  input  logic        blank_lz_i,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  n_digit_o,
  output logic        frame_done_o
);

  localparam int            CW            = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SLOT_END  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            pending_q, pending_d;
  disp_val_t       shadow_q, shadow_d;
  disp_val_t       active_q, active_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [3:0]      n_digit_q, n_digit_d;
  logic            frame_done_q, frame_done_d;
  logic            ready_q, ready_d;

  logic            boundary_s;
  logic            transfer_s;
  logic            load_ok_s;
  logic [3:0]      zero_s;
  logic [3:0]      protect_s;
  logic [3:0]      keep_s;
  logic [3:0]      blank_mask_s;
  logic [3:0]      dec_code_s;
  logic [6:0]      dec_seg_s;

  // The boundary is the last drive cycle of digit 3; in IDLE a pending value moves immediately.
  assign boundary_s = enable_i && (state_q == DRIVE) && (idx_q == 2'd3) && (cnt_q == CNT_SLOT_END);
  assign transfer_s = pending_q && (boundary_s || (state_q == IDLE));
  assign load_ok_s  = load_i && !pending_q;

  // Scan sequencing: slot counter, digit index and frame pulse.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
        BLANK: begin
          if (cnt_q == CNT_BLANK_END) begin
            state_d = DRIVE;
          end else begin
            state_d = BLANK;
          end
          cnt_d = cnt_q + CNT_ONE;
        end
        DRIVE: begin
          if (cnt_q == CNT_SLOT_END) begin
            state_d      = BLANK;
            cnt_d        = '0;
            idx_d        = idx_q + 2'd1;
            frame_done_d = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // Shadow capture on accepted load and shadow-to-active transfer.
  always_comb begin
    if (load_ok_s) begin
      shadow_d  = '{code: digit_code_i, dp_en: dp_en_i, dp_pos: dp_pos_i, blank_lz: blank_lz_i};
      pending_d = 1'b1;
    end else if (transfer_s) begin
      shadow_d  = shadow_q;
      pending_d = 1'b0;
    end else begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
    end
    if (transfer_s) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
    ready_d = !pending_d;
  end

  // Per-digit zero detect and DP protection against blanking.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zero_s[k]    = (active_q.code[4*k +: 4] == 4'h0);
      protect_s[k] = active_q.dp_en && (2'(k) <= active_q.dp_pos);
      keep_s[k]    = zero_s[k] && !protect_s[k];
    end
  end

  // A digit blanks only when every digit to its left is also blanked.
  assign blank_mask_s[3] = active_q.blank_lz && keep_s[3];
  assign blank_mask_s[2] = active_q.blank_lz && keep_s[3] && keep_s[2];
  assign blank_mask_s[1] = active_q.blank_lz && (&keep_s[3:1]);
  assign blank_mask_s[0] = 1'b0;

  // Select the digit that will be shown in the next cycle.
  always_comb begin
    case (idx_d)
      2'd0:    dec_code_s = active_q.code[3:0];
      2'd1:    dec_code_s = active_q.code[7:4];
      2'd2:    dec_code_s = active_q.code[11:8];
      2'd3:    dec_code_s = active_q.code[15:12];
      default: dec_code_s = 4'h0;
    endcase
  end

  seg_hex_decode u_decode (
    .code_i (dec_code_s),
    .seg_o  (dec_seg_s)
  );

  // Next output values, derived from the next state so outputs stay registered.
  always_comb begin
    if (state_d == DRIVE) begin
      n_digit_d = ~(4'b0001 << idx_d);
      seg_d     = blank_mask_s[idx_d] ? SEG_OFF : dec_seg_s;
      dp_d      = active_q.dp_en && (idx_d == active_q.dp_pos);
    end else begin
      n_digit_d = 4'b1111;
      seg_d     = SEG_OFF;
      dp_d      = 1'b0;
    end
  end

  // All state and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      pending_q    <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b0;
      n_digit_q    <= 4'b1111;
      frame_done_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      n_digit_q    <= n_digit_d;
      frame_done_q <= frame_done_d;
      ready_q      <= ready_d;
    end
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign n_digit_o    = n_digit_q;
  assign frame_done_o = frame_done_q;
  assign ready_o      = ready_q;

endmodule
